// File: rtl/tl_pkg.sv
// Shared types for the intersection light controller.
//   NUM_LANES / COUNT_W : lane count and car-count width (NNEESSWW order)
//   WAIT_W              : width of the per-lane starvation wait counters
//   phase_e             : controller phase as seen on the phase output
//   lowestSet()         : keeps only the lowest-index set bit of a lane vector
package tl_pkg;

  localparam int NUM_LANES = 8;
  localparam int COUNT_W   = 8;
  localparam int WAIT_W    = 6;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_e;

  typedef logic [NUM_LANES-1:0] lane_vec_t;

  // v & -v isolates the lowest set bit; returns 0 for an empty vector.
  function automatic lane_vec_t lowestSet(input lane_vec_t v);
    lane_vec_t neg;
    neg = ~v + lane_vec_t'(1);
    return v & neg;
  endfunction

endpackage

// File: rtl/lane_wait_tracker.sv
// Per-lane starvation tracking.
//   clk, rst        : clock, synchronous active-high reset
//   car_counts      : per-lane car counts
//   served          : lanes that are green now or are being granted green
//   starved_any     : some lane has waited at least STARVE_LIMIT cycles
//   starved_onehot  : lowest-index starved lane
module lane_wait_tracker
  import tl_pkg::*;
#(
  parameter int STARVE_LIMIT = 24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_LANES-1:0][COUNT_W-1:0]    car_counts,
  input  logic [NUM_LANES-1:0]                 served,
  output logic                                 starved_any,
  output logic [NUM_LANES-1:0]                 starved_onehot
);

  lane_vec_t hasCars;
  lane_vec_t starvedVec;

  for (genvar i = 0; i < NUM_LANES; i++) begin : gHas
    assign hasCars[i] = |car_counts[i];
  end

  lane_wait_cell #(.STARVE_LIMIT(STARVE_LIMIT)) uCell [NUM_LANES-1:0] (
    .clk     (clk),
    .rst     (rst),
    .hasCars (hasCars),
    .served  (served),
    .starved (starvedVec)
  );

  assign starved_any    = |starvedVec;
  assign starved_onehot = lowestSet(starvedVec);

endmodule

// One lane's saturating wait counter.
//   hasCars : lane count is non-zero
//   served  : lane is green or being granted; holds the counter at zero
//   starved : wait >= STARVE_LIMIT
module lane_wait_cell
  import tl_pkg::*;
#(
  parameter int STARVE_LIMIT = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic hasCars,
  input  logic served,
  output logic starved
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] waitCnt;

  always_ff @(posedge clk) begin
    if (rst)                     waitCnt <= '0;
    else if (!hasCars || served) waitCnt <= '0;
    else if (waitCnt != '1)      waitCnt <= waitCnt + 1'b1;
  end

  assign starved = (waitCnt >= LIMIT);

endmodule

// File: rtl/light_phase_controller.sv
// Turns the instantaneous busiest-lane choice into a legal light sequence:
// min/max green, fixed yellow and all-red clearance, starvation override.
//   clk, rst   : clock, synchronous active-high reset
//   car_counts : per-lane car counts, index 0..7 = N1,N2,E1,E2,S1,S2,W1,W2
//   max_lane   : one-hot busiest lane (multi-hot reduced to lowest index)
//   green      : one-hot green lane, registered
//   yellow     : one-hot yellow lane, registered
//   phase      : current phase (phase_e encoding)
module light_phase_controller
  import tl_pkg::*;
#(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 16,
  parameter int YELLOW       = 2,
  parameter int ALL_RED      = 1,
  parameter int STARVE_LIMIT = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LANES-1:0][COUNT_W-1:0] car_counts,
  input  logic [NUM_LANES-1:0]              max_lane,
  output logic [NUM_LANES-1:0]              green,
  output logic [NUM_LANES-1:0]              yellow,
  output logic [1:0]                        phase
);

  // One timer serves all timed phases, so size it for the longest one.
  localparam int TMAX0   = (MAX_GREEN > YELLOW) ? MAX_GREEN : YELLOW;
  localparam int TMAX    = (TMAX0 > ALL_RED) ? TMAX0 : ALL_RED;
  localparam int TIMER_W = $clog2(TMAX + 1);

  localparam logic [TIMER_W-1:0] MIN_T = TIMER_W'(MIN_GREEN);
  localparam logic [TIMER_W-1:0] MAX_T = TIMER_W'(MAX_GREEN);
  localparam logic [TIMER_W-1:0] YEL_T = TIMER_W'(YELLOW);
  localparam logic [TIMER_W-1:0] RED_T = TIMER_W'(ALL_RED);

  phase_e             state, stateNxt;
  lane_vec_t          greenNxt, yellowNxt;
  logic [TIMER_W-1:0] timer, timerNxt, elapsed;

  logic      starvedAny;
  lane_vec_t starvedOne;
  lane_vec_t hasCars;
  lane_vec_t maxReduced, pick;
  logic      pickValid, curEmpty, starvedOther, maxOther, leaveGreen;

  lane_wait_tracker #(.STARVE_LIMIT(STARVE_LIMIT)) uWait (
    .clk            (clk),
    .rst            (rst),
    .car_counts     (car_counts),
    .served         (green | greenNxt),
    .starved_any    (starvedAny),
    .starved_onehot (starvedOne)
  );

  for (genvar i = 0; i < NUM_LANES; i++) begin : gHas
    assign hasCars[i] = |car_counts[i];
  end

  assign maxReduced = lowestSet(max_lane);
  assign pick       = starvedAny ? starvedOne : maxReduced;
  assign pickValid  = |pick;

  // elapsed counts the green cycle that ends at this edge.
  assign elapsed      = timer + 1'b1;
  assign curEmpty     = ~|(green & hasCars);
  // The served lane's wait is held at zero, so it never shows up as starved.
  assign starvedOther = |(starvedOne & ~green);
  assign maxOther     = (|maxReduced) && (maxReduced != green);
  assign leaveGreen   = (elapsed >= MIN_T) &&
                        (curEmpty || starvedOther || maxOther || elapsed == MAX_T);

  always_comb begin
    stateNxt  = state;
    greenNxt  = green;
    yellowNxt = yellow;
    timerNxt  = timer;
    case (state)
      PH_IDLE: begin
        greenNxt  = '0;
        yellowNxt = '0;
        if (pickValid) begin
          stateNxt = PH_GREEN;
          greenNxt = pick;
          timerNxt = '0;
        end
      end
      PH_GREEN: begin
        timerNxt = elapsed;
        if (leaveGreen) begin
          stateNxt  = PH_YELLOW;
          yellowNxt = green;
          greenNxt  = '0;
          timerNxt  = '0;
        end
      end
      PH_YELLOW: begin
        timerNxt = elapsed;
        if (elapsed == YEL_T) begin
          stateNxt  = PH_ALLRED;
          yellowNxt = '0;
          timerNxt  = '0;
        end
      end
      PH_ALLRED: begin
        timerNxt = elapsed;
        if (elapsed == RED_T) begin
          timerNxt = '0;
          if (pickValid) begin
            stateNxt = PH_GREEN;
            greenNxt = pick;
          end else begin
            stateNxt = PH_IDLE;
          end
        end
      end
      default: begin
        stateNxt  = PH_IDLE;
        greenNxt  = '0;
        yellowNxt = '0;
        timerNxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PH_IDLE;
      green  <= '0;
      yellow <= '0;
      timer  <= '0;
    end else begin
      state  <= stateNxt;
      green  <= greenNxt;
      yellow <= yellowNxt;
      timer  <= timerNxt;
    end
  end

  assign phase = state;

endmodule
